// File: rtl/writeback_stage_if.sv
// Writeback stage bus: execute-side result handoff, data-memory load port
// and register-file write port.
interface writeback_stage_if;
  logic        instr_valid;
  logic [1:0]  wb_sel;
  logic [4:0]  rd_in;
  logic        reg_en;
  logic [31:0] alu_result;
  logic [31:0] imm;
  logic [31:0] pc;
  logic [2:0]  funct3;
  logic [31:0] mem_data;
  logic        mem_ack;
  logic        mem_req;
  logic        busy;
  logic [31:0] reg_write;
  logic        write;
  logic [4:0]  rd;
  logic        err;

  modport master (
    output instr_valid, wb_sel, rd_in, reg_en, alu_result, imm, pc, funct3,
           mem_data, mem_ack,
    input  mem_req, busy, reg_write, write, rd, err
  );

  modport slave (
    input  instr_valid, wb_sel, rd_in, reg_en, alu_result, imm, pc, funct3,
           mem_data, mem_ack,
    output mem_req, busy, reg_write, write, rd, err
  );
endinterface

// File: rtl/writeback_stage.sv
// Writeback stage: selects ALU/load/PC+4/IMM result, waits for load data
// with a bounded timeout and issues a single register-file write.
//
// state     | meaning
// IDLE      | accepting instr_valid
// LOAD_WAIT | mem_req held, waiting for mem_ack or timeout
// COMMIT    | one-cycle register-file write slot
module writeback_stage #(
  parameter int TIMEOUT = 15
) (
  input logic             clk,
  input logic             rst,
  writeback_stage_if.slave wb
);
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, LOAD_WAIT, COMMIT} state_t;

  state_t      state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [1:0]  off_q;
  logic [2:0]  f3_q;
  logic [4:0]  rd_lat;
  logic        wen_lat;
  logic        accept;
  logic        load_legal;
  logic [31:0] lane;
  logic [31:0] load_val;
  logic [31:0] src_val;
  logic        wr_n, err_n;
  logic [31:0] wdata_n;
  logic [4:0]  wrd_n;
  logic        busy_q, mem_req_q, write_q, err_q;
  logic [31:0] reg_write_q;
  logic [4:0]  rd_q;

  assign accept = (state == IDLE) && wb.instr_valid;

  always_comb begin
    load_legal = 1'b0;
    case (wb.funct3)
      3'b000, 3'b100: load_legal = 1'b1;
      3'b001, 3'b101: load_legal = ~wb.alu_result[0];
      3'b010:         load_legal = (wb.alu_result[1:0] == 2'b00);
      default:        load_legal = 1'b0;
    endcase
  end

  // Byte/halfword lane is selected by the offset latched at acceptance.
  always_comb begin
    lane = wb.mem_data >> {off_q, 3'b000};
    case (f3_q)
      3'b000:  load_val = {{24{lane[7]}}, lane[7:0]};
      3'b100:  load_val = {24'd0, lane[7:0]};
      3'b001:  load_val = {{16{lane[15]}}, lane[15:0]};
      3'b101:  load_val = {16'd0, lane[15:0]};
      default: load_val = wb.mem_data;
    endcase
  end

  always_comb begin
    case (wb.wb_sel)
      2'b00:   src_val = wb.alu_result;
      2'b10:   src_val = wb.pc + 32'd4;
      default: src_val = wb.imm;
    endcase
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    wr_n    = 1'b0;
    err_n   = 1'b0;
    wdata_n = reg_write_q;
    wrd_n   = rd_q;
    case (state)
      IDLE: begin
        if (wb.instr_valid) begin
          if (wb.wb_sel != 2'b01) begin
            state_n = COMMIT;
            wr_n    = wb.reg_en && (wb.rd_in != 5'd0);
            if (wr_n) begin
              wdata_n = src_val;
              wrd_n   = wb.rd_in;
            end
          end else if (load_legal) begin
            state_n = LOAD_WAIT;
            cnt_n   = CW'(TIMEOUT - 1);
          end else begin
            err_n = 1'b1;
          end
        end
      end
      LOAD_WAIT: begin
        // mem_ack wins over an expiring counter on the same edge.
        if (wb.mem_ack) begin
          state_n = COMMIT;
          cnt_n   = '0;
          wr_n    = wen_lat;
          if (wen_lat) begin
            wdata_n = load_val;
            wrd_n   = rd_lat;
          end
        end else if (cnt == '0) begin
          state_n = IDLE;
          err_n   = 1'b1;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      COMMIT:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      off_q       <= 2'd0;
      f3_q        <= 3'd0;
      rd_lat      <= 5'd0;
      wen_lat     <= 1'b0;
      busy_q      <= 1'b0;
      mem_req_q   <= 1'b0;
      write_q     <= 1'b0;
      err_q       <= 1'b0;
      reg_write_q <= 32'd0;
      rd_q        <= 5'd0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      busy_q      <= (state_n != IDLE);
      mem_req_q   <= (state_n == LOAD_WAIT);
      write_q     <= wr_n;
      err_q       <= err_n;
      reg_write_q <= wdata_n;
      rd_q        <= wrd_n;
      if (accept) begin
        off_q   <= wb.alu_result[1:0];
        f3_q    <= wb.funct3;
        rd_lat  <= wb.rd_in;
        wen_lat <= wb.reg_en && (wb.rd_in != 5'd0);
      end
    end
  end

  assign wb.busy      = busy_q;
  assign wb.mem_req   = mem_req_q;
  assign wb.write     = write_q;
  assign wb.err       = err_q;
  assign wb.reg_write = reg_write_q;
  assign wb.rd        = rd_q;
endmodule

// File: tb/tb_writeback_stage.sv
// Bench for writeback_stage: directed vector table, reset corner cases and
// randomized transactions checked against a behavioural model.
module tb_writeback_stage;
  localparam int TIMEOUT = 15;

  logic clk;
  logic rst;
  writeback_stage_if wb_bus ();

  writeback_stage #(.TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .wb  (wb_bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  sel;
    logic [4:0]  rd;
    logic        en;
    logic [31:0] alu;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [2:0]  f3;
    logic [31:0] md;
    int          ack;     // mem_req cycle on which mem_ack is given; 0 = never
    int          e_req;
    int          e_busy;
    int          e_err;
    int          e_wr;
    logic [31:0] e_data;
  } vec_t;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] last_data = 32'd0;
  logic [4:0]  last_rd   = 5'd0;
  vec_t        tbl[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [1:0] sel, input logic [4:0] rd, input logic en,
                              input logic [31:0] alu, input logic [31:0] imm, input logic [31:0] pc,
                              input logic [2:0] f3, input logic [31:0] md, input int ack,
                              input int e_req, input int e_busy, input int e_err, input int e_wr,
                              input logic [31:0] e_data);
    vec_t v;
    v.sel = sel; v.rd = rd; v.en = en; v.alu = alu; v.imm = imm; v.pc = pc;
    v.f3 = f3; v.md = md; v.ack = ack;
    v.e_req = e_req; v.e_busy = e_busy; v.e_err = e_err; v.e_wr = e_wr; v.e_data = e_data;
    return v;
  endfunction

  function automatic vec_t model(input vec_t v);
    int          off;
    logic [31:0] b, h;
    logic        legal, wen;
    off = int'(v.alu % 4);
    wen = v.en && (v.rd != 5'd0);
    b = (v.md >> (8 * off)) & 32'hFF;
    h = (v.md >> (8 * off)) & 32'hFFFF;
    v.e_req = 0; v.e_busy = 0; v.e_err = 0; v.e_wr = 0; v.e_data = 32'd0;
    if (v.sel != 2'd1) begin
      v.e_busy = 1;
      v.e_wr   = wen ? 1 : 0;
      v.e_data = (v.sel == 2'd0) ? v.alu : (v.sel == 2'd2) ? v.pc + 32'd4 : v.imm;
    end else begin
      case (v.f3)
        3'd0, 3'd4: legal = 1'b1;
        3'd1, 3'd5: legal = (off % 2) == 0;
        3'd2:       legal = (off == 0);
        default:    legal = 1'b0;
      endcase
      if (!legal) begin
        v.e_err = 1;
      end else if (v.ack >= 1 && v.ack <= TIMEOUT) begin
        v.e_req  = v.ack;
        v.e_busy = v.ack + 1;
        v.e_wr   = wen ? 1 : 0;
        case (v.f3)
          3'd0:    v.e_data = (b >= 128) ? b - 32'd256 : b;
          3'd4:    v.e_data = b;
          3'd1:    v.e_data = (h >= 32768) ? h - 32'd65536 : h;
          3'd5:    v.e_data = h;
          default: v.e_data = v.md;
        endcase
      end else begin
        v.e_req  = TIMEOUT;
        v.e_busy = TIMEOUT;
        v.e_err  = 1;
      end
    end
    return v;
  endfunction

  // Called just after a falling edge; returns just after a falling edge.
  task automatic run_vec(input vec_t v, input string tag);
    int          n_req, n_busy, n_err, n_wr, wcyc;
    logic [31:0] gd;
    logic [4:0]  grd;
    n_req = 0; n_busy = 0; n_err = 0; n_wr = 0; wcyc = -1; gd = 32'd0; grd = 5'd0;
    wb_bus.instr_valid = 1'b1;
    wb_bus.wb_sel      = v.sel;
    wb_bus.rd_in       = v.rd;
    wb_bus.reg_en      = v.en;
    wb_bus.alu_result  = v.alu;
    wb_bus.imm         = v.imm;
    wb_bus.pc          = v.pc;
    wb_bus.funct3      = v.f3;
    wb_bus.mem_ack     = 1'b0;
    wb_bus.mem_data    = $urandom;
    @(posedge clk);
    for (int c = 0; c < 22; c++) begin
      @(negedge clk);
      if (wb_bus.mem_req) n_req++;
      if (wb_bus.busy)    n_busy++;
      if (wb_bus.err)     n_err++;
      if (wb_bus.write) begin
        n_wr++;
        gd  = wb_bus.reg_write;
        grd = wb_bus.rd;
        if (wcyc < 0) wcyc = c;
      end
      // Junk traffic that the stage must ignore while busy / outside LOAD_WAIT.
      wb_bus.instr_valid = wb_bus.busy ? 1'($urandom % 2) : 1'b0;
      wb_bus.wb_sel      = 2'($urandom);
      wb_bus.rd_in       = 5'($urandom);
      wb_bus.alu_result  = $urandom;
      wb_bus.funct3      = 3'($urandom);
      if (wb_bus.mem_req) begin
        wb_bus.mem_ack  = (n_req == v.ack);
        wb_bus.mem_data = (n_req == v.ack) ? v.md : $urandom;
      end else begin
        wb_bus.mem_ack  = 1'($urandom % 2);
        wb_bus.mem_data = $urandom;
      end
    end
    wb_bus.instr_valid = 1'b0;
    wb_bus.mem_ack     = 1'b0;
    chk({tag, " mem_req cycles"}, n_req, v.e_req);
    chk({tag, " busy cycles"}, n_busy, v.e_busy);
    chk({tag, " err pulses"}, n_err, v.e_err);
    chk({tag, " write pulses"}, n_wr, v.e_wr);
    if (v.e_wr != 0) begin
      last_data = v.e_data;
      last_rd   = v.rd;
      chk({tag, " write data"}, gd, v.e_data);
      chk({tag, " write rd"}, 32'(grd), 32'(v.rd));
      chk({tag, " write latency"}, wcyc, (v.sel == 2'd1) ? v.ack : 0);
    end
    chk({tag, " reg_write held"}, wb_bus.reg_write, last_data);
    chk({tag, " rd held"}, 32'(wb_bus.rd), 32'(last_rd));
  endtask

  initial begin
    vec_t v;
    int   n_bad;

    tbl.push_back(mk(2'd0, 5'd5, 1'b1, 32'h1234, 0, 0, 3'd0, 0, 0,  0, 1, 0, 1, 32'h0000_1234));
    tbl.push_back(mk(2'd1, 5'd7, 1'b1, 32'h103, 0, 0, 3'd0, 32'h80FF_0000, 3, 3, 4, 0, 1, 32'hFFFF_FF80));
    tbl.push_back(mk(2'd1, 5'd7, 1'b1, 32'h103, 0, 0, 3'd4, 32'h80FF_0000, 3, 3, 4, 0, 1, 32'h0000_0080));
    tbl.push_back(mk(2'd3, 5'd0, 1'b1, 0, 32'hABCD_0000, 0, 3'd0, 0, 0, 0, 1, 0, 0, 32'd0));
    tbl.push_back(mk(2'd1, 5'd3, 1'b1, 32'h102, 0, 0, 3'd2, 32'h1111_2222, 1, 0, 0, 1, 0, 32'd0));
    tbl.push_back(mk(2'd2, 5'd1, 1'b1, 0, 0, 32'hFFFF_FFFC, 3'd0, 0, 0, 0, 1, 0, 1, 32'h0000_0000));
    tbl.push_back(mk(2'd1, 5'd8, 1'b1, 32'h42, 0, 0, 3'd1, 32'h8001_1234, 1, 1, 2, 0, 1, 32'hFFFF_8001));
    tbl.push_back(mk(2'd1, 5'd8, 1'b1, 32'h42, 0, 0, 3'd5, 32'h8001_1234, 1, 1, 2, 0, 1, 32'h0000_8001));
    tbl.push_back(mk(2'd1, 5'd4, 1'b1, 32'h100, 0, 0, 3'd2, 32'h1111_1111, 0, 15, 15, 1, 0, 32'd0));
    tbl.push_back(mk(2'd1, 5'd4, 1'b1, 32'h100, 0, 0, 3'd2, 32'hDEAD_BEEF, 15, 15, 16, 0, 1, 32'hDEAD_BEEF));
    tbl.push_back(mk(2'd1, 5'd6, 1'b1, 32'h100, 0, 0, 3'd3, 32'h5555_5555, 2, 0, 0, 1, 0, 32'd0));
    tbl.push_back(mk(2'd1, 5'd6, 1'b1, 32'h101, 0, 0, 3'd1, 32'h5555_5555, 2, 0, 0, 1, 0, 32'd0));
    tbl.push_back(mk(2'd0, 5'd9, 1'b0, 32'h55, 0, 0, 3'd0, 0, 0, 0, 1, 0, 0, 32'd0));
    tbl.push_back(mk(2'd1, 5'd10, 1'b1, 32'h201, 0, 0, 3'd0, 32'h0000_7F00, 2, 2, 3, 0, 1, 32'h0000_007F));
    tbl.push_back(mk(2'd1, 5'd6, 1'b1, 32'h0, 0, 0, 3'd6, 32'h5555_5555, 2, 0, 0, 1, 0, 32'd0));

    rst = 1'b1;
    wb_bus.instr_valid = 1'b1;
    wb_bus.wb_sel = 2'd0; wb_bus.rd_in = 5'd3; wb_bus.reg_en = 1'b1;
    wb_bus.alu_result = 32'hFFFF_FFFF; wb_bus.imm = 32'd0; wb_bus.pc = 32'd0;
    wb_bus.funct3 = 3'd0; wb_bus.mem_data = 32'd0; wb_bus.mem_ack = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset busy", 32'(wb_bus.busy), 0);
    chk("reset mem_req", 32'(wb_bus.mem_req), 0);
    chk("reset write", 32'(wb_bus.write), 0);
    chk("reset err", 32'(wb_bus.err), 0);
    chk("reset reg_write", wb_bus.reg_write, 0);
    chk("reset rd", 32'(wb_bus.rd), 0);

    // First vector is presented as rst falls, so it rides the first edge.
    rst = 1'b0;
    foreach (tbl[i]) run_vec(tbl[i], $sformatf("vec%0d", i));

    // Reset during LOAD_WAIT.
    wb_bus.instr_valid = 1'b1; wb_bus.wb_sel = 2'd1; wb_bus.rd_in = 5'd9;
    wb_bus.reg_en = 1'b1; wb_bus.alu_result = 32'h200; wb_bus.funct3 = 3'd2;
    wb_bus.mem_ack = 1'b0;
    @(posedge clk);
    @(negedge clk);
    wb_bus.instr_valid = 1'b0;
    chk("midload mem_req before reset", 32'(wb_bus.mem_req), 1);
    repeat (2) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("midload mem_req async drop", 32'(wb_bus.mem_req), 0);
    chk("midload busy async drop", 32'(wb_bus.busy), 0);
    chk("midload reg_write cleared", wb_bus.reg_write, 0);
    last_data = 32'd0;
    last_rd   = 5'd0;
    @(negedge clk);
    rst = 1'b0;
    wb_bus.mem_ack = 1'b1;
    wb_bus.mem_data = 32'hCAFE_F00D;
    n_bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (wb_bus.write || wb_bus.mem_req || wb_bus.busy) n_bad++;
    end
    chk("midload activity after release", n_bad, 0);
    wb_bus.mem_ack = 1'b0;
    run_vec(mk(2'd0, 5'd12, 1'b1, 32'h0BAD_F00D, 0, 0, 3'd0, 0, 0, 0, 1, 0, 1, 32'h0BAD_F00D),
            "post-reset alu");

    for (int k = 0; k < 300; k++) begin
      v.sel = ($urandom % 2) ? 2'd1 : 2'($urandom);
      v.rd  = (($urandom % 8) == 0) ? 5'd0 : 5'($urandom);
      v.en  = ($urandom % 6) != 0;
      v.alu = $urandom;
      v.imm = $urandom;
      v.pc  = (($urandom % 8) == 0) ? 32'hFFFF_FFFC : $urandom;
      v.f3  = 3'($urandom);
      v.md  = $urandom;
      v.ack = int'($urandom_range(0, TIMEOUT + 3));
      v = model(v);
      run_vec(v, $sformatf("rand%0d", k));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/writeback_stage.md
WRITEBACK_STAGE -- requirements
Module: writeback_stage

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15: max cycles spent in LOAD_WAIT before abort.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port rst  input  1  reset; asynchronous and active-high.
REQ-004 SHALL have port instr_valid  input  1  one-cycle strobe; execute result is presented.
REQ-005 SHALL have port wb_sel  input  2  writeback source: 00 ALU, 01 MEM load, 10 PC+4, 11 IMM.
REQ-006 SHALL have port rd_in  input  5  destination register index.
REQ-007 SHALL have port reg_en  input  1  instruction writes a register.
REQ-008 SHALL have ports alu_result, imm, pc  input  32 each  candidate sources.
REQ-009 SHALL have port funct3  input  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
REQ-010 SHALL have port mem_data  input  32  aligned word from data memory.
REQ-011 SHALL have port mem_ack  input  1  mem_data is valid this cycle.
REQ-012 SHALL have port mem_req  output  1  load request to data memory.
REQ-013 SHALL have port busy  output  1  stage not accepting instr_valid.
REQ-014 SHALL have ports reg_write 32, write 1, rd 5  outputs  register-file write data, enable, index.
REQ-015 SHALL have port err  output  1  one-cycle pulse: misaligned, illegal funct3 or timeout.

Function
REQ-016 SHALL implement FSM states IDLE, LOAD_WAIT, COMMIT; all outputs registered.
REQ-017 SHALL, in IDLE with instr_valid=1, latch every input; wb_sel!=01 -> COMMIT; wb_sel=01 and legal -> LOAD_WAIT.
REQ-018 SHALL ignore instr_valid whenever busy=1; busy=1 in LOAD_WAIT and COMMIT.
REQ-019 SHALL hold mem_req=1 for every LOAD_WAIT cycle, deasserting on the edge that samples mem_ack=1.
REQ-020 SHALL, on sampling mem_ack=1 in LOAD_WAIT, latch the extracted load value and go to COMMIT.
REQ-021 SHALL extract loads using latched alu_result[1:0] as byte offset: LB/LBU byte at offset*8, LH/LHU halfword at offset*8 (offset 0 or 2), LW whole word; LB/LH sign-extend, LBU/LHU zero-extend to 32 bits.
REQ-022 SHALL compute PC+4 modulo 2^32 (0xFFFFFFFC -> 0x00000000).
REQ-023 SHALL, in COMMIT, drive write=1 for exactly one cycle with reg_write and rd holding the selected value, then return to IDLE.
REQ-024 SHALL force write=0 in COMMIT when latched rd_in=0 or reg_en=0; the FSM timing is unchanged.
REQ-025 SHALL hold reg_write and rd at last values when write=0.
REQ-026 SHALL treat LH/LHU with offset 1 or 3, LW with offset!=0, or funct3 in {011,110,111} as illegal: err pulses the cycle after acceptance, no mem_req, no write, stay IDLE.
REQ-027 SHALL count LOAD_WAIT cycles; after TIMEOUT cycles without mem_ack: err pulse, mem_req=0, no write, return to IDLE.
REQ-028 SHALL give mem_ack priority over timeout when both occur on the same edge.
REQ-029 SHALL ignore mem_ack outside LOAD_WAIT.
REQ-030 SHALL have latency: non-load accepted at edge N -> write=1 during cycle after N; load acked at edge M -> write=1 during cycle after M.

Reset
REQ-031 SHALL, while rst=1, immediately force state IDLE, mem_req=0, busy=0, write=0, err=0, reg_write=0, rd=0, timeout counter=0.
REQ-032 SHALL abandon any load or pending commit on reset, with no write after release.
REQ-033 SHALL accept instr_valid on the first rising edge after rst falls.

Verification
REQ-034 SHALL verify ALU path: wb_sel=00, rd_in=5, alu_result=0x1234 -> next cycle write=1, rd=5, reg_write=0x1234, busy high one cycle.
REQ-035 SHALL verify LB sign extension: funct3=000, alu_result=0x103, mem_data=0x80FF0000, ack after 3 cycles -> mem_req high 3 cycles, reg_write=0xFFFFFF80; LBU same -> 0x00000080.
REQ-036 SHALL verify rd=0 suppression: wb_sel=11, imm=0xABCD0000, rd_in=0 -> write stays 0, busy pulses one cycle.
REQ-037 SHALL verify misaligned LW at alu_result=0x102 -> err pulse, mem_req never asserted, write=0.
REQ-038 SHALL verify timeout: LW with no mem_ack -> mem_req high 15 cycles, err pulse, no write; mem_ack on cycle 15 -> write instead, err=0.
REQ-039 SHALL verify reset mid-load: rst asserted in LOAD_WAIT -> mem_req drops without clock edge, no write after release, next ALU instruction commits normally.
